// File: rtl/shot_sequencer_if.sv
// Board-side signal bundle of the shot sequencer: raw key/switch inputs and validated shot outputs.
// master drives the raw inputs, slave is the sequencer itself.
interface shot_sequencer_if;
  logic       key_n;
  logic       new_game;
  logic [3:0] sw_x;
  logic [3:0] sw_y;
  logic       sw_big;
  logic       shot_valid;
  logic [3:0] shot_x;
  logic [3:0] shot_y;
  logic       shot_big;
  logic       wrong;
  logic [1:0] big_left;
  logic [6:0] shot_count;

  modport master (
    output key_n, new_game, sw_x, sw_y, sw_big,
    input  shot_valid, shot_x, shot_y, shot_big, wrong, big_left, shot_count
  );

  modport slave (
    input  key_n, new_game, sw_x, sw_y, sw_big,
    output shot_valid, shot_x, shot_y, shot_big, wrong, big_left, shot_count
  );
endinterface

// File: rtl/shot_sequencer.sv
// Turns a score-key press into one validated shot (coordinate/bomb checks, counters); shot_valid
// follows the 4th edge after the key goes low. Optional key debounce when SHOT_DEBOUNCE_EN is defined.
module shot_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BIG_BOMBS       = 2
) (
  input  logic            clock,
  input  logic            reset_L,
  shot_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, FIRE, ERROR, WAIT_RELEASE} state_t;

  localparam logic [1:0] BIG_INIT = 2'(BIG_BOMBS);

  state_t     state, state_nxt;
  logic       sync1, sync2, filt, filt_prev;
  logic [1:0] settle;
  logic       armed;
  logic       press_evt;
  logic       capture, set_wrong, fire, bad_shot;
  logic [3:0] shot_x_q, shot_y_q;
  logic       shot_big_q, wrong_q;
  logic [1:0] big_left_q;
  logic [6:0] shot_count_q;

  // Key synchronizer. armed only rises once the synchronized key has been seen released
  // after reset, so a key held through reset cannot fake a press.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      filt_prev <= 1'b1;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync1     <= bus.key_n;
      sync2     <= sync1;
      filt_prev <= filt;
      settle    <= {settle[0], 1'b1};
      armed     <= armed | (settle[1] & sync2);
    end
  end

`ifdef SHOT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt;
  logic          filt_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      db_cnt <= '0;
      filt_q <= 1'b1;
    end else if (sync2 == filt_q) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign filt = sync2;
`endif

  assign press_evt = armed & filt_prev & ~filt;
  assign bad_shot  = (shot_x_q < 4'd1) || (shot_x_q > 4'd10) ||
                     (shot_y_q < 4'd1) || (shot_y_q > 4'd10) ||
                     (shot_big_q && (big_left_q == 2'd0));

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    set_wrong = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (press_evt) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (bad_shot) begin
          set_wrong = 1'b1;
          state_nxt = ERROR;
        end else begin
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        fire      = 1'b1;
        state_nxt = WAIT_RELEASE;
      end
      ERROR:        state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: if (filt) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
    // new_game wins over anything the FSM wanted to do this cycle
    if (bus.new_game) begin
      state_nxt = IDLE;
      capture   = 1'b0;
      set_wrong = 1'b0;
      fire      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      shot_x_q     <= '0;
      shot_y_q     <= '0;
      shot_big_q   <= 1'b0;
      wrong_q      <= 1'b0;
      big_left_q   <= BIG_INIT;
      shot_count_q <= '0;
    end else begin
      if (capture) begin
        shot_x_q   <= bus.sw_x;
        shot_y_q   <= bus.sw_y;
        shot_big_q <= bus.sw_big;
      end
      if (bus.new_game) begin
        wrong_q      <= 1'b0;
        big_left_q   <= BIG_INIT;
        shot_count_q <= '0;
      end else begin
        if (capture)   wrong_q <= 1'b0;
        if (set_wrong) wrong_q <= 1'b1;
        if (fire && shot_count_q != 7'd127) shot_count_q <= shot_count_q + 7'd1;
        if (fire && shot_big_q && big_left_q != 2'd0) big_left_q <= big_left_q - 2'd1;
      end
    end
  end

  assign bus.shot_valid = fire;
  assign bus.shot_x     = shot_x_q;
  assign bus.shot_y     = shot_y_q;
  assign bus.shot_big   = shot_big_q;
  assign bus.wrong      = wrong_q;
  assign bus.big_left   = big_left_q;
  assign bus.shot_count = shot_count_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer (default build, no debounce): stimulus pushes expected shots, a monitor checks each pulse.
module tb_shot_sequencer;

  logic clock = 1'b0;
  logic reset_L;
  always #5 clock = ~clock;

  shot_sequencer_if bus();

  shot_sequencer #(.DEBOUNCE_CYCLES(16), .BIG_BOMBS(2)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       big;
  } shot_t;

  shot_t exp_q[$];
  int    nvec = 0;
  int    nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every shot_valid pulse must match the oldest outstanding expected shot.
  always @(negedge clock) begin
    if (reset_L && bus.shot_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_shot_valid", 1, 0);
      end else begin
        shot_t e;
        e = exp_q.pop_front();
        check("shot_x", int'(bus.shot_x), int'(e.x));
        check("shot_y", int'(bus.shot_y), int'(e.y));
        check("shot_big", int'(bus.shot_big), int'(e.big));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One key press; switches are scrambled right after capture to prove they are latched.
  task automatic press(input logic [3:0] x, input logic [3:0] y, input logic big,
                       input int hold, input bit fire);
    shot_t s;
    @(negedge clock);
    bus.sw_x   = x;
    bus.sw_y   = y;
    bus.sw_big = big;
    bus.key_n  = 1'b0;
    if (fire) begin
      s.x = x; s.y = y; s.big = big;
      exp_q.push_back(s);
    end
    repeat (3) @(negedge clock);
    check("valid_before_edge4", int'(bus.shot_valid), 0);
    bus.sw_x   = ~x;
    bus.sw_y   = ~y;
    bus.sw_big = ~big;
    @(negedge clock);
    check("valid_after_edge4", int'(bus.shot_valid), int'(fire));
    repeat (hold - 4) @(negedge clock);
    bus.key_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic pulse_new_game();
    @(negedge clock);
    bus.new_game = 1'b1;
    @(negedge clock);
    bus.new_game = 1'b0;
  endtask

  initial begin
    reset_L      = 1'b0;
    bus.key_n    = 1'b1;
    bus.new_game = 1'b0;
    bus.sw_x     = 4'd0;
    bus.sw_y     = 4'd0;
    bus.sw_big   = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_shot_valid", int'(bus.shot_valid), 0);
    check("rst_shot_x", int'(bus.shot_x), 0);
    check("rst_shot_y", int'(bus.shot_y), 0);
    check("rst_shot_big", int'(bus.shot_big), 0);
    check("rst_wrong", int'(bus.wrong), 0);
    check("rst_big_left", int'(bus.big_left), 2);
    check("rst_shot_count", int'(bus.shot_count), 0);
    reset_L = 1'b1;
    repeat (4) @(negedge clock);

    // Basic valid shot
    press(4'd5, 4'd7, 1'b0, 6, 1'b1);
    check("basic_count", int'(bus.shot_count), 1);
    check("basic_big_left", int'(bus.big_left), 2);
    check("basic_wrong", int'(bus.wrong), 0);
    check("basic_hold_x", int'(bus.shot_x), 5);
    check("basic_hold_y", int'(bus.shot_y), 7);

    pulse_new_game();
    check("ng_count", int'(bus.shot_count), 0);
    check("ng_big_left", int'(bus.big_left), 2);

    // Out-of-range coordinates, then recovery
    press(4'd0, 4'd4, 1'b0, 6, 1'b0);
    check("x0_wrong", int'(bus.wrong), 1);
    check("x0_count", int'(bus.shot_count), 0);
    press(4'd11, 4'd3, 1'b0, 6, 1'b0);
    check("x11_wrong", int'(bus.wrong), 1);
    check("x11_count", int'(bus.shot_count), 0);
    press(4'd3, 4'd3, 1'b0, 6, 1'b1);
    check("recover_wrong", int'(bus.wrong), 0);
    check("recover_count", int'(bus.shot_count), 1);

    // Big bombs run out after two
    press(4'd2, 4'd2, 1'b1, 6, 1'b1);
    check("big1_left", int'(bus.big_left), 1);
    press(4'd2, 4'd2, 1'b1, 6, 1'b1);
    check("big2_left", int'(bus.big_left), 0);
    press(4'd2, 4'd2, 1'b1, 6, 1'b0);
    check("big3_wrong", int'(bus.wrong), 1);
    check("big3_left", int'(bus.big_left), 0);
    check("big3_count", int'(bus.shot_count), 3);

    // Long hold still gives one shot
    press(4'd8, 4'd9, 1'b0, 50, 1'b1);
    check("hold_count", int'(bus.shot_count), 4);

    // new_game in the same cycle as the press event
    @(negedge clock);
    bus.sw_x = 4'd6; bus.sw_y = 4'd6; bus.sw_big = 1'b0;
    bus.key_n = 1'b0;
    repeat (2) @(negedge clock);
    bus.new_game = 1'b1;
    @(negedge clock);
    bus.new_game = 1'b0;
    repeat (12) @(negedge clock);
    check("ngpress_count", int'(bus.shot_count), 0);
    check("ngpress_big_left", int'(bus.big_left), 2);
    check("ngpress_wrong", int'(bus.wrong), 0);
    check("ngpress_x_kept", int'(bus.shot_x), 8);
    bus.key_n = 1'b1;
    repeat (5) @(negedge clock);
    press(4'd1, 4'd10, 1'b0, 6, 1'b1);
    check("edge_1_10_count", int'(bus.shot_count), 1);
    press(4'd10, 4'd1, 1'b1, 6, 1'b1);
    check("edge_10_1_left", int'(bus.big_left), 1);
    check("edge_10_1_count", int'(bus.shot_count), 2);

    // Reset while the FSM is in CHECK, key held through and after reset
    @(negedge clock);
    bus.sw_x = 4'd4; bus.sw_y = 4'd4; bus.sw_big = 1'b1;
    bus.key_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_L = 1'b0;
    #1;
    check("midrst_valid", int'(bus.shot_valid), 0);
    check("midrst_shot_x", int'(bus.shot_x), 0);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (12) @(negedge clock);
    check("midrst_count", int'(bus.shot_count), 0);
    check("midrst_big_left", int'(bus.big_left), 2);
    check("midrst_wrong", int'(bus.wrong), 0);
    bus.key_n = 1'b1;
    repeat (5) @(negedge clock);
    press(4'd4, 4'd4, 1'b0, 6, 1'b1);
    check("midrst_repress_count", int'(bus.shot_count), 1);

    // Saturation: 130 more valid shots
    for (int i = 0; i < 130; i++) begin
      press(4'((i % 10) + 1), 4'(((i * 3) % 10) + 1), 1'b0, 5, 1'b1);
      if (i == 125) check("count_126", int'(bus.shot_count), 127);
    end
    check("sat_count", int'(bus.shot_count), 127);

    repeat (4) @(negedge clock);
    check("pending_shots", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
